counter_ctrl: RTL

Command-driven sequencer for the 32-bit up/down counter datapath. It generates the prescaled count-enable tick, the direction, and the load/clear strobes, and detects the terminal count against a programmable target. It sits between the command source (CPU register file or test FSM) and the counter register. The count register itself lives in the datapath; this block only observes it through `cnt_q`.

---
 rtl/counter_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/counter_ctrl.sv
// Command-driven sequencer for the up/down counter datapath: prescaled tick, direction,
// load/clear strobes and terminal-count detection. Optional sticky irq with CNT_CTRL_IRQ_EN.
module counter_ctrl #(
  parameter int WIDTH = 32,
  parameter int PRE_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_tick,
  output logic             cnt_up,
  output logic             cnt_load,
  output logic             cnt_clr,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             done,
  output logic             busy
`ifdef CNT_CTRL_IRQ_EN
  ,
  output logic             irq,
  input  logic             irq_clr
`endif
);

  localparam logic [2:0] OP_SET_PRE    = 3'd0;
  localparam logic [2:0] OP_SET_TGT    = 3'd1;
  localparam logic [2:0] OP_LOAD       = 3'd2;
  localparam logic [2:0] OP_START_UP   = 3'd3;
  localparam logic [2:0] OP_START_DOWN = 3'd4;
  localparam logic [2:0] OP_STOP       = 3'd5;
  localparam logic [2:0] OP_CLEAR      = 3'd6;
  localparam logic [2:0] OP_SET_MODE   = 3'd7;

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRE_W-1:0] PRE_ONE = {{(PRE_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_r, state_nxt_s;
  logic [PRE_W-1:0]   pre_cnt_r, pre_cnt_nxt_s;
  logic [PRE_W-1:0]   pre_max_r;
  logic [WIDTH-1:0]   target_r;
  logic               one_shot_r;
  logic               acc_s, op_start_s, op_load_s, op_clear_s, strobe_s;
  logic               tick_due_s, tick_s, term_s, cnt_up_nxt_s;
  logic [WIDTH-1:0]   next_cnt_s;

  // Command decode, next-state, prescaler and terminal-count logic
  always_comb begin
    state_nxt_s   = state_r;
    pre_cnt_nxt_s = pre_cnt_r;
    cnt_up_nxt_s  = cnt_up;
    acc_s         = cmd_valid && cmd_ready;
    op_start_s    = acc_s && ((cmd_op == OP_START_UP) || (cmd_op == OP_START_DOWN));
    op_load_s     = acc_s && (cmd_op == OP_LOAD);
    op_clear_s    = acc_s && (cmd_op == OP_CLEAR);
    strobe_s      = op_load_s || op_clear_s;
    // The datapath applies cnt_tick at the coming edge, so predict the value it will show.
    next_cnt_s    = cnt_up ? (cnt_q + CNT_ONE) : (cnt_q - CNT_ONE);
    term_s        = cnt_tick && (next_cnt_s == target_r);
    tick_due_s    = (state_r == ST_RUN) && (pre_cnt_r >= pre_max_r);

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (op_start_s) state_nxt_s = ST_RUN;
        else            state_nxt_s = state_r;
      end
      ST_RUN: begin
        if (acc_s && (cmd_op == OP_STOP))  state_nxt_s = ST_IDLE;
        else if (op_start_s)               state_nxt_s = ST_RUN;
        else if (term_s && one_shot_r)     state_nxt_s = ST_DONE;
        else                               state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase

    // A strobe owns the datapath this cycle; reaching DONE must not overshoot the target.
    tick_s = tick_due_s && !strobe_s && (state_nxt_s != ST_DONE);

    if (state_r != ST_RUN) pre_cnt_nxt_s = '0;
    else if (tick_due_s)   pre_cnt_nxt_s = '0;
    else                   pre_cnt_nxt_s = pre_cnt_r + PRE_ONE;

    if (op_start_s) cnt_up_nxt_s = (cmd_op == OP_START_UP);
    else            cnt_up_nxt_s = cnt_up;
  end

  // State, prescaler and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      pre_cnt_r    <= '0;
      cnt_tick     <= 1'b0;
      cnt_up       <= 1'b1;
      cnt_load     <= 1'b0;
      cnt_clr      <= 1'b0;
      cnt_load_val <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      cmd_ready    <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      pre_cnt_r <= pre_cnt_nxt_s;
      cnt_tick  <= tick_s;
      cnt_up    <= cnt_up_nxt_s;
      cnt_load  <= op_load_s;
      cnt_clr   <= op_clear_s;
      done      <= term_s;
      busy      <= (state_nxt_s == ST_RUN);
      cmd_ready <= !strobe_s;
      if (op_load_s) cnt_load_val <= cmd_data;
    end
  end

  // Programmable configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_max_r  <= '0;
      target_r   <= '1;
      one_shot_r <= 1'b1;
    end else if (acc_s) begin
      case (cmd_op)
        OP_SET_PRE:  pre_max_r  <= cmd_data[PRE_W-1:0];
        OP_SET_TGT:  target_r   <= cmd_data;
        OP_SET_MODE: one_shot_r <= cmd_data[0];
        default:     one_shot_r <= one_shot_r;
      endcase
    end
  end

`ifdef CNT_CTRL_IRQ_EN
  // Sticky interrupt; a done pulse outranks any clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst)                         irq <= 1'b0;
    else if (done)                   irq <= 1'b1;
    else if (irq_clr || op_clear_s)  irq <= 1'b0;
  end
`endif

endmodule
